mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the shared data-side port (port B) of the boot ROM and main RAM block memories. It accepts word fetches from a debug/prefetch requester and load/store requests from the core's memory stage, grants one access per cycle, and drives the port B address, enables, byte-lane write strobes and store data. It also tracks the single outstanding read so that the registered ROM/RAM output is returned, lane-aligned and extended, to the correct requester one cycle later.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_load_align.sv | 24 ++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-side memory port: request ops, access sizes,
// the default ROM/RAM split, the read-tracking FSM states and store-lane helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_LOAD_S = 2'b01,
    OP_LOAD_U = 2'b10,
    OP_STORE  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  localparam logic [31:0] ROM_TOP_DEFAULT = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD_F = 2'b01,
    ST_RD_D = 2'b10
  } arb_state_e;

  function automatic logic [3:0] store_strobe(input mem_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: store_strobe = 4'b0001 << off;
      SZ_HALF: store_strobe = 4'b0011 << off;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  // Replicating the datum lets the strobes alone pick the destination lane.
  function automatic logic [31:0] store_data(input mem_size_e sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: store_data = {4{wd[7:0]}};
      SZ_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load return formatting: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  mem_size_e   size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Port B sequencer: arbitrates fetch and data requests one access per cycle,
// drives the ROM/RAM port, and routes the 1-cycle-late read data back.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] ROM_TOP = ROM_TOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fReq,
  input  logic [31:0] fAddr,
  output logic        fGnt,
  output logic        fRvalid,
  output logic [31:0] fRdata,
  input  logic        dReq,
  input  logic [1:0]  dOp,
  input  logic [1:0]  dSize,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic        dGnt,
  output logic        dErr,
  output logic        dRvalid,
  output logic [31:0] dRdata,
  output logic [31:0] memAddr,
  output logic [3:0]  wen,
  output logic [31:0] din,
  output logic        romEnB,
  output logic        ramEnB,
  input  logic [31:0] romDout,
  input  logic [31:0] ramDout,
  output arb_state_e  dbgState
);

  // Handshake: a requester raises xReq with stable fields and keeps them until
  // the cycle xGnt (or dErr) is high; that cycle is the transfer, no back-pressure after.
  mem_op_e    d_op;
  mem_size_e  d_size;
  logic       d_active, d_store, d_misalign, d_illegal, d_legal;
  logic       f_win, d_win;

  arb_state_e state_q;
  logic       last_d_q;
  logic       f_rvalid_q, d_rvalid_q;
  logic       rd_rom_q, rd_sign_q;
  logic [1:0] rd_off_q;
  mem_size_e  rd_size_q;

  logic [31:0] rd_word, rd_aligned;

  assign d_op   = mem_op_e'(dOp);
  assign d_size = mem_size_e'(dSize);

  always_comb begin
    d_active = dReq && (d_op != OP_NONE) && !rst;
    d_store  = (d_op == OP_STORE);
    case (d_size)
      SZ_HALF: d_misalign = dAddr[0];
      SZ_WORD: d_misalign = |dAddr[1:0];
      SZ_RSVD: d_misalign = 1'b1;
      default: d_misalign = 1'b0;
    endcase
    d_illegal = d_active && (d_misalign || (d_store && (dAddr <= ROM_TOP)));
    d_legal   = d_active && !d_illegal;
    // Fetch only overtakes a legal data request right after a data grant.
    f_win     = fReq && !rst && (!d_legal || last_d_q);
    d_win     = d_legal && !f_win;
  end

  always_comb begin
    fGnt    = f_win;
    dGnt    = d_win;
    dErr    = d_illegal;
    memAddr = '0;
    wen     = '0;
    din     = '0;
    romEnB  = 1'b0;
    ramEnB  = 1'b0;
    if (f_win) begin
      memAddr = fAddr;
      romEnB  = (fAddr <= ROM_TOP);
      ramEnB  = (fAddr > ROM_TOP);
    end else if (d_win) begin
      memAddr = dAddr;
      if (d_store) begin
        ramEnB = 1'b1;
        wen    = store_strobe(d_size, dAddr[1:0]);
        din    = store_data(d_size, dWdata);
      end else begin
        romEnB = (dAddr <= ROM_TOP);
        ramEnB = (dAddr > ROM_TOP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_d_q   <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      rd_rom_q   <= 1'b0;
      rd_sign_q  <= 1'b0;
      rd_off_q   <= 2'b00;
      rd_size_q  <= SZ_WORD;
    end else begin
      if (f_win) begin
        last_d_q <= 1'b0;
      end else if (d_win) begin
        last_d_q <= 1'b1;
      end
      if (f_win) begin
        state_q    <= ST_RD_F;
        f_rvalid_q <= 1'b1;
        d_rvalid_q <= 1'b0;
        rd_rom_q   <= (fAddr <= ROM_TOP);
        rd_sign_q  <= 1'b0;
        rd_off_q   <= 2'b00;
        rd_size_q  <= SZ_WORD;
      end else if (d_win && !d_store) begin
        state_q    <= ST_RD_D;
        f_rvalid_q <= 1'b0;
        d_rvalid_q <= 1'b1;
        rd_rom_q   <= (dAddr <= ROM_TOP);
        rd_sign_q  <= (d_op == OP_LOAD_S);
        rd_off_q   <= dAddr[1:0];
        rd_size_q  <= d_size;
      end else begin
        state_q    <= ST_IDLE;
        f_rvalid_q <= 1'b0;
        d_rvalid_q <= 1'b0;
      end
    end
  end

  assign rd_word = rd_rom_q ? romDout : ramDout;

  mem_load_align u_align (
    .word_i (rd_word),
    .off_i  (rd_off_q),
    .size_i (rd_size_q),
    .sign_i (rd_sign_q),
    .data_o (rd_aligned)
  );

  // A reset landing on the return cycle swallows the response.
  assign fRvalid  = f_rvalid_q && !rst;
  assign dRvalid  = d_rvalid_q && !rst;
  assign fRdata   = fRvalid ? rd_word : '0;
  assign dRdata   = dRvalid ? rd_aligned : '0;
  assign dbgState = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic,
// all checked against a byte-level memory and request-level reference model.
module tb_mem_port_arbiter;

  localparam logic [31:0] ROM_TOP = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        fReq;
  logic [31:0] fAddr;
  logic        fGnt, fRvalid;
  logic [31:0] fRdata;
  logic        dReq;
  logic [1:0]  dOp, dSize;
  logic [31:0] dAddr, dWdata;
  logic        dGnt, dErr, dRvalid;
  logic [31:0] dRdata, memAddr;
  logic [3:0]  wen;
  logic [31:0] din;
  logic        romEnB, ramEnB;
  logic [31:0] romDout = 32'h0;
  logic [31:0] ramDout = 32'h0;
  mem_pkg::arb_state_e dbg_state;

  mem_port_arbiter #(.ROM_TOP(ROM_TOP)) dut (
    .clk(clk), .rst(rst),
    .fReq(fReq), .fAddr(fAddr), .fGnt(fGnt), .fRvalid(fRvalid), .fRdata(fRdata),
    .dReq(dReq), .dOp(dOp), .dSize(dSize), .dAddr(dAddr), .dWdata(dWdata),
    .dGnt(dGnt), .dErr(dErr), .dRvalid(dRvalid), .dRdata(dRdata),
    .memAddr(memAddr), .wen(wen), .din(din), .romEnB(romEnB), .ramEnB(ramEnB),
    .romDout(romDout), .ramDout(ramDout), .dbgState(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  logic        exp_fv = 1'b0, exp_dv = 1'b0;
  logic [31:0] exp_fd = 32'h0, exp_dd = 32'h0;
  logic        last_d = 1'b0;
  logic        g_f = 1'b0, g_d = 1'b0, g_err = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] key;
    key = {a[31:2], 2'b00};
    if (mem.exists(key)) return mem[key];
    return (key * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void mem_wr_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = mem_rd(a);
    w[8*a[1:0] +: 8] = b;
    mem[{a[31:2], 2'b00}] = w;
  endfunction

  function automatic logic [31:0] load_ref(input logic [31:0] w, input logic [1:0] off,
                                           input int nb, input logic sgn);
    logic [31:0] mask, v;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v = (w >> (8 * off)) & mask;
    if (sgn && nb < 4 && ((v & (mask ^ (mask >> 1))) != 0)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 127));
      1:       return 32'h0000_FFC0 + 32'($urandom_range(0, 127));
      default: return 32'h0001_0000 + 32'($urandom_range(0, 127));
    endcase
  endfunction

  // Memory behind port B: registered read, contents owned by the bench.
  always @(posedge clk) begin
    if (romEnB) romDout <= mem_rd(memAddr);
    if (ramEnB) ramDout <= mem_rd(memAddr);
  end

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  // One clock: checks at the falling edge, returns 1ns after the rising edge.
  task automatic step_cycle();
    logic d_any, d_bad, d_ok, eg_f, eg_d, e_rom, e_ram;
    logic [31:0] e_addr, e_din, nb_l;
    logic [3:0] e_wen;
    int nb;
    @(negedge clk);
    if (rst) begin
      chk("rst_fRvalid", fRvalid, 0); chk("rst_fRdata", fRdata, 0);
      chk("rst_dRvalid", dRvalid, 0); chk("rst_dRdata", dRdata, 0);
      chk("rst_fGnt", fGnt, 0); chk("rst_dGnt", dGnt, 0); chk("rst_dErr", dErr, 0);
      chk("rst_memAddr", memAddr, 0); chk("rst_wen", wen, 0); chk("rst_din", din, 0);
      chk("rst_romEnB", romEnB, 0); chk("rst_ramEnB", ramEnB, 0);
      exp_fv = 0; exp_dv = 0; last_d = 0; g_f = 0; g_d = 0; g_err = 0;
    end else begin
      chk("fRvalid", fRvalid, exp_fv);
      if (exp_fv) chk("fRdata", fRdata, exp_fd);
      chk("dRvalid", dRvalid, exp_dv);
      if (exp_dv) chk("dRdata", dRdata, exp_dd);
      d_any = dReq && (dOp != 2'b00);
      nb    = 1 << dSize;
      nb_l  = 32'(nb);
      d_bad = d_any && (dSize == 2'b11 || (dAddr & (nb_l - 32'd1)) != 0 ||
                        (dOp == 2'b11 && dAddr <= ROM_TOP));
      d_ok  = d_any && !d_bad;
      eg_f  = fReq && (!d_ok || last_d);
      eg_d  = d_ok && !eg_f;
      e_addr = 0; e_wen = 0; e_din = 0; e_rom = 0; e_ram = 0;
      if (eg_f) begin
        e_addr = fAddr; e_rom = (fAddr <= ROM_TOP); e_ram = !e_rom;
      end else if (eg_d) begin
        e_addr = dAddr;
        if (dOp == 2'b11) begin
          e_ram = 1;
          e_wen = 4'(((1 << nb) - 1) << dAddr[1:0]);
          e_din = (nb == 1) ? dWdata[7:0] * 32'h0101_0101 :
                  (nb == 2) ? dWdata[15:0] * 32'h0001_0001 : dWdata;
        end else begin
          e_rom = (dAddr <= ROM_TOP); e_ram = !e_rom;
        end
      end
      chk("fGnt", fGnt, eg_f); chk("dGnt", dGnt, eg_d); chk("dErr", dErr, d_bad);
      chk("memAddr", memAddr, e_addr); chk("wen", wen, e_wen); chk("din", din, e_din);
      chk("romEnB", romEnB, e_rom); chk("ramEnB", ramEnB, e_ram);
      exp_fv = eg_f;
      exp_fd = mem_rd(fAddr);
      exp_dv = eg_d && (dOp != 2'b11);
      exp_dd = load_ref(mem_rd(dAddr), dAddr[1:0], nb, dOp == 2'b01);
      if (eg_d && dOp == 2'b11)
        for (int i = 0; i < nb; i++) mem_wr_byte(dAddr + 32'(i), dWdata[8*i +: 8]);
      if (eg_f) last_d = 0;
      else if (eg_d) last_d = 1;
      g_f = eg_f; g_d = eg_d; g_err = d_bad;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; fReq = 0; fAddr = 0; dReq = 0; dOp = 0; dSize = 0; dAddr = 0; dWdata = 0;
    mem[32'h0000_0010] = 32'hDEAD_BEEF;
    mem[32'h0001_0000] = 32'h8001_1234;
    @(posedge clk); #1;
    step_cycle(); step_cycle();
    rst = 0;
    step_cycle();

    // Lone fetch from ROM
    fReq = 1; fAddr = 32'h0000_0010; #1;
    chk("t1_fGnt", fGnt, 1); chk("t1_romEnB", romEnB, 1);
    step_cycle(); fReq = 0;
    chk("t1_fRvalid", fRvalid, 1); chk("t1_fRdata", fRdata, 32'hDEAD_BEEF);

    // Sustained contention alternates starting with data
    fReq = 1; fAddr = 32'h0000_0020;
    dReq = 1; dOp = 2'b10; dSize = 2'b10; dAddr = 32'h0001_0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_dGnt", dGnt, (i % 2 == 0)); chk("t2_fGnt", fGnt, (i % 2 == 1));
      step_cycle();
    end
    fReq = 0; dReq = 0;
    step_cycle();

    // Half loads, signed then unsigned
    dReq = 1; dOp = 2'b01; dSize = 2'b01; dAddr = 32'h0001_0002;
    step_cycle(); dReq = 0;
    chk("t3_lds", dRdata, 32'hFFFF_8001);
    dReq = 1; dOp = 2'b10;
    step_cycle(); dReq = 0;
    chk("t3_ldu", dRdata, 32'h0000_8001);

    // Byte store into the top lane
    dReq = 1; dOp = 2'b11; dSize = 2'b00; dAddr = 32'h0001_0003; dWdata = 32'h0000_00A5; #1;
    chk("t4_wen", wen, 4'b1000); chk("t4_din", din, 32'hA5A5_A5A5); chk("t4_ramEnB", ramEnB, 1);
    step_cycle(); dReq = 0;
    chk("t4_dRvalid", dRvalid, 0);

    // Rejected: misaligned word load, store into ROM range
    dReq = 1; dOp = 2'b01; dSize = 2'b10; dAddr = 32'h0001_0002; #1;
    chk("t5a_dErr", dErr, 1); chk("t5a_en", {romEnB, ramEnB}, 0);
    step_cycle(); dReq = 0;
    dReq = 1; dOp = 2'b11; dSize = 2'b10; dAddr = 32'h0000_0100; dWdata = 32'h1122_3344; #1;
    chk("t5b_dErr", dErr, 1); chk("t5b_en", {romEnB, ramEnB}, 0);
    step_cycle(); dReq = 0;
    chk("t5b_dRvalid", dRvalid, 0);
    step_cycle();

    // Reset during the return cycle drops the response and the priority
    dReq = 1; dOp = 2'b10; dSize = 2'b10; dAddr = 32'h0000_0010;
    step_cycle(); dReq = 0; rst = 1; #1;
    chk("t6_dRvalid", dRvalid, 0); chk("t6_dRdata", dRdata, 0);
    step_cycle(); rst = 0;
    fReq = 1; fAddr = 32'h0000_0010;
    dReq = 1; dOp = 2'b10; dSize = 2'b10; dAddr = 32'h0001_0004; #1;
    chk("t6_post_dRvalid", dRvalid, 0);
    chk("t6_dGnt", dGnt, 1); chk("t6_fGnt", fGnt, 0);
    step_cycle(); dReq = 0;
    step_cycle(); fReq = 0;
    step_cycle();

    // Randomized traffic from both requesters
    for (int it = 0; it < 400; it++) begin
      if (!fReq || g_f) begin
        fReq  = ($urandom_range(0, 3) != 0);
        fAddr = rand_addr() & 32'hFFFF_FFFC;
      end
      if (!dReq || g_d || g_err || dOp == 2'b00) begin
        dReq   = ($urandom_range(0, 3) != 0);
        dOp    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        dSize  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        dAddr  = rand_addr();
        if (dSize != 2'b11 && $urandom_range(0, 4) != 0)
          dAddr = dAddr & ~(32'(1 << dSize) - 32'd1);
        dWdata = $urandom;
      end
      step_cycle();
    end
    fReq = 0; dReq = 0;
    step_cycle(); step_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
